// File: rtl/uart_baud_ctrl.sv
// Baud-rate tick generator: divides CE pulses by a runtime divisor into oversample
// ticks, then by OVS into bit ticks, with immediate or terminal-count-aligned divisor updates.
module uart_baud_ctrl #(
  parameter int unsigned      DIV_W     = 16,
  parameter int unsigned      OVS       = 16,
  parameter logic [DIV_W-1:0] RESET_DIV = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             RUN_EN,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [DIV_W-1:0] CFG_DIV,
  input  logic             CFG_IMM,
  output logic             TICK_OVS,
  output logic             TICK_BIT,
  output logic [DIV_W-1:0] DIV_CUR,
  output logic             ACTIVE
);

  localparam int unsigned    BCW      = $clog2(OVS);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(OVS - 1);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cur, div_cur_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [DIV_W-1:0] staged, staged_nxt;
  logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
  logic             tick_ovs, tick_ovs_nxt;
  logic             tick_bit, tick_bit_nxt;
  logic             accept;
  logic             terminal;

  assign CFG_READY = (state != PEND);
  assign ACTIVE    = (state != IDLE);
  assign TICK_OVS  = tick_ovs;
  assign TICK_BIT  = tick_bit;
  assign DIV_CUR   = div_cur;

  assign accept   = CFG_VALID & CFG_READY;
  // div_cur is never 0 outside IDLE, so DIV_CUR-1 cannot underflow where this is used.
  assign terminal = CE && (div_cnt == div_cur - DIV_W'(1));

  always_comb begin
    // NOTE: every next-state value gets its hold/default first so no path infers a latch.
    state_nxt    = state;
    div_cur_nxt  = div_cur;
    div_cnt_nxt  = div_cnt;
    staged_nxt   = staged;
    bit_cnt_nxt  = bit_cnt;
    tick_ovs_nxt = 1'b0;
    tick_bit_nxt = 1'b0;

    case (state)
      IDLE: begin
        div_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (accept) div_cur_nxt = CFG_DIV;
        if (RUN_EN && (div_cur_nxt != '0)) state_nxt = RUN;
      end

      RUN, PEND: begin
        if (!RUN_EN) begin
          // Leaving early still honours a divisor that was waiting for its boundary.
          if (state == PEND) div_cur_nxt = staged;
          staged_nxt  = '0;
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else if ((state == RUN) && accept && CFG_IMM) begin
          div_cur_nxt = CFG_DIV;
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = (CFG_DIV == '0) ? IDLE : RUN;
        end else begin
          if ((state == RUN) && accept) begin
            staged_nxt = CFG_DIV;
            state_nxt  = PEND;
          end
          if (terminal) begin
            div_cnt_nxt  = '0;
            tick_ovs_nxt = 1'b1;
            tick_bit_nxt = (bit_cnt == BIT_LAST);
            bit_cnt_nxt  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BCW'(1);
            if (state == PEND) begin
              // The old period completes first; the staged divisor governs the next one.
              div_cur_nxt = staged;
              staged_nxt  = '0;
              if (staged == '0) begin
                bit_cnt_nxt = '0;
                state_nxt   = IDLE;
              end else begin
                state_nxt = RUN;
              end
            end
          end else if (CE) begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      div_cur  <= RESET_DIV;
      div_cnt  <= '0;
      staged   <= '0;
      bit_cnt  <= '0;
      tick_ovs <= 1'b0;
      tick_bit <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cur  <= div_cur_nxt;
      div_cnt  <= div_cnt_nxt;
      staged   <= staged_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tick_ovs <= tick_ovs_nxt;
      tick_bit <= tick_bit_nxt;
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl: expected tick times are queued as stimulus is
// driven and matched against TICK_OVS/TICK_BIT by a negedge monitor.
module tb_uart_baud_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE;
  logic        RUN_EN;
  logic        CFG_VALID;
  logic        CFG_READY;
  logic [15:0] CFG_DIV;
  logic        CFG_IMM;
  logic        TICK_OVS;
  logic        TICK_BIT;
  logic [15:0] DIV_CUR;
  logic        ACTIVE;

  uart_baud_ctrl #(.DIV_W(16), .OVS(16), .RESET_DIV(16'd9)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .RUN_EN(RUN_EN),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_DIV(CFG_DIV), .CFG_IMM(CFG_IMM),
    .TICK_OVS(TICK_OVS), .TICK_BIT(TICK_BIT), .DIV_CUR(DIV_CUR), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int   at;
    logic bt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Tick scoreboard: every TICK_OVS must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!RST) begin
      check("bit_needs_ovs", {31'd0, TICK_BIT & ~TICK_OVS}, 32'd0);
      if (TICK_OVS) begin
        check("tick_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tick_cycle", cyc, e.at);
          check("tick_bit", {31'd0, TICK_BIT}, {31'd0, e.bt});
        end
      end else if ((exp_q.size() > 0) && (exp_q[0].at <= cyc)) begin
        check("tick_missing", {31'd0, TICK_OVS}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic ce, input logic run, input logic exp_tick, input logic exp_bit);
    CE     = ce;
    RUN_EN = run;
    if (exp_tick) exp_q.push_back('{cyc + 1, exp_bit});
    @(posedge CLK);
    #1;
    CFG_VALID = 1'b0;
  endtask

  task automatic offer(input logic [15:0] div, input logic imm, input logic ce, input logic run,
                       input logic exp_tick, input logic exp_bit);
    CFG_VALID = 1'b1;
    CFG_DIV   = div;
    CFG_IMM   = imm;
    drive(ce, run, exp_tick, exp_bit);
  endtask

  task automatic drain();
    CE     = 1'b0;
    RUN_EN = 1'b0;
    @(negedge CLK);
    #1;
    check("q_drained", exp_q.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; CE = 1'b0; RUN_EN = 1'b0;
    CFG_VALID = 1'b0; CFG_DIV = '0; CFG_IMM = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_tick_ovs", {31'd0, TICK_OVS}, 32'd0);
    check("rst_tick_bit", {31'd0, TICK_BIT}, 32'd0);
    check("rst_active", {31'd0, ACTIVE}, 32'd0);
    check("rst_div_cur", DIV_CUR, 32'd9);
    check("rst_cfg_ready", {31'd0, CFG_READY}, 32'd1);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // DIV 4, CE constant: ovs tick every 4 cycles, bit tick on every 16th
    offer(16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a_div_cur", DIV_CUR, 32'd4);
    check("a_idle", {31'd0, ACTIVE}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("a_active", {31'd0, ACTIVE}, 32'd1);
    for (int i = 0; i < 68; i++)
      drive(1'b1, 1'b1, (i % 4) == 3, ((i % 4) == 3) && (((i / 4) + 1) % 16 == 0));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("a_stopped", {31'd0, ACTIVE}, 32'd0);
    drain();

    // DIV 3, CE every other cycle: period 6
    offer(16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++)
      drive((i % 2) == 0, 1'b1, ((i % 2) == 0) && (((i / 2) % 3) == 2), 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // DIV 1, CE constant: tick every cycle, stop cycle issues none
    offer(16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      drive(1'b1, 1'b1, 1'b1, ((i + 1) % 16) == 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // DIV 10 at count 3, deferred change to 5
    offer(16'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("d_ready_run", {31'd0, CFG_READY}, 32'd1);
    offer(16'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("d_ready_pend", {31'd0, CFG_READY}, 32'd0);
    check("d_div_kept", DIV_CUR, 32'd10);
    for (int j = 0; j < 16; j++) begin
      if (j == 1) offer(16'd77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      else        drive(1'b1, 1'b1, (j >= 5) && ((j % 5) == 0), 1'b0);
      if (j == 5) begin
        check("d_div_new", DIV_CUR, 32'd5);
        check("d_ready_back", {31'd0, CFG_READY}, 32'd1);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // DIV 10 at count 3 (one tick already), immediate change to 5 clears bit counter
    offer(16'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) drive(1'b1, 1'b1, i == 9, 1'b0);
    offer(16'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("e_div_new", DIV_CUR, 32'd5);
    check("e_ready", {31'd0, CFG_READY}, 32'd1);
    for (int j = 0; j < 80; j++)
      drive(1'b1, 1'b1, (j % 5) == 4, ((j % 5) == 4) && ((j / 5) + 1 == 16));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Immediate change on a terminal CE suppresses that tick; immediate 0 stops
    offer(16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    offer(16'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b1, (i % 7) == 6, 1'b0);
    offer(16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("g_imm0_active", {31'd0, ACTIVE}, 32'd0);
    check("g_imm0_div", DIV_CUR, 32'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("g_stays_idle", {31'd0, ACTIVE}, 32'd0);
    drain();

    // Deferred change to 0: old terminal tick still issued, then stopped
    offer(16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    offer(16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("f_active", {31'd0, ACTIVE}, 32'd0);
    check("f_div_cur", DIV_CUR, 32'd0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("f_still_idle", {31'd0, ACTIVE}, 32'd0);
    check("f_ready", {31'd0, CFG_READY}, 32'd1);
    drain();

    // RUN_EN drop in PEND commits the staged divisor
    offer(16'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    offer(16'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("c_pend", {31'd0, CFG_READY}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("c_idle", {31'd0, ACTIVE}, 32'd0);
    check("c_commit", DIV_CUR, 32'd6);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, (i % 6) == 5, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Asynchronous reset in PEND
    offer(16'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    offer(16'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("r_pend", {31'd0, CFG_READY}, 32'd0);
    #2;
    RST = 1'b1;
    #1;
    check("r_tick_ovs", {31'd0, TICK_OVS}, 32'd0);
    check("r_tick_bit", {31'd0, TICK_BIT}, 32'd0);
    check("r_active", {31'd0, ACTIVE}, 32'd0);
    check("r_div_cur", DIV_CUR, 32'd9);
    check("r_ready", {31'd0, CFG_READY}, 32'd1);
    @(posedge CLK);
    #1;
    RST = 1'b0; CE = 1'b0; RUN_EN = 1'b0;
    @(posedge CLK);
    #1;
    check("r_ready_rel", {31'd0, CFG_READY}, 32'd1);
    check("r_div_rel", DIV_CUR, 32'd9);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, i == 8, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
